fft8_out_reader: RTL and testbench

FFT8_OUT_READER -- requirements
Module: fft8_out_reader

---
 rtl/fft8_pkg.sv | 17 +
 rtl/fft8_mag_est.sv | 41 ++++
 rtl/fft8_out_reader.sv | 142 ++++++++++++++
 tb/tb_fft8_out_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared definitions for the FFT8 core and its output reader: sample format,
// frame size and the reader's two-state FSM encoding.
package fft8_pkg;

    localparam int DW     = 16;
    localparam int NBINS  = 8;
    localparam int FRAC_W = 8;
    localparam int IDX_W  = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/fft8_mag_est.sv
// Combinational magnitude estimate: max(|re|,|im|) + min(|re|,|im|)/2.
// Absolute values are taken as unsigned so the most negative code maps to 2^(DW-1).
module fft8_mag_est #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] re_i,
    input  logic [DW-1:0] im_i,
    output logic [DW-1:0] mag_o
);

    function automatic logic [DW-1:0] abs_u(input logic signed [DW-1:0] x);
        logic [DW-1:0] r;
        r = x[DW-1] ? (~x + 1'b1) : x;
        return r;
    endfunction

    logic signed [DW-1:0] re_s;
    logic signed [DW-1:0] im_s;
    logic [DW-1:0]        abs_re;
    logic [DW-1:0]        abs_im;
    logic [DW-1:0]        max_v;
    logic [DW-1:0]        min_v;

    assign re_s   = re_i;
    assign im_s   = im_i;
    assign abs_re = abs_u(re_s);
    assign abs_im = abs_u(im_s);

    always_comb begin
        max_v = abs_re;
        min_v = abs_im;
        if (abs_im > abs_re) begin
            max_v = abs_im;
            min_v = abs_re;
        end
    end

    // max <= 2^(DW-1) and min/2 <= 2^(DW-2), so the sum always fits in DW bits.
    assign mag_o = max_v + (min_v >> 1);

endmodule

// File: rtl/fft8_out_reader.sv
// Serialises one parallel 8-bin FFT frame into a valid/ready bin stream with
// a magnitude estimate, a last-bin marker and a sticky dropped-frame flag.
module fft8_out_reader #(
    parameter int DW    = 16,
    parameter int NBINS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in1_real,
    input  logic [DW-1:0] in2_real,
    input  logic [DW-1:0] in3_real,
    input  logic [DW-1:0] in4_real,
    input  logic [DW-1:0] in5_real,
    input  logic [DW-1:0] in6_real,
    input  logic [DW-1:0] in7_real,
    input  logic [DW-1:0] in8_real,
    input  logic [DW-1:0] in1_imag,
    input  logic [DW-1:0] in2_imag,
    input  logic [DW-1:0] in3_imag,
    input  logic [DW-1:0] in4_imag,
    input  logic [DW-1:0] in5_imag,
    input  logic [DW-1:0] in6_imag,
    input  logic [DW-1:0] in7_imag,
    input  logic [DW-1:0] in8_imag,
    input  logic          in_stb,
    output logic [DW-1:0] bin_real,
    output logic [DW-1:0] bin_imag,
    output logic [2:0]    bin_idx,
    output logic [DW-1:0] bin_mag,
    output logic          bin_valid,
    input  logic          bin_ready,
    output logic          bin_last,
    output logic          busy,
    output logic          overflow,
    input  logic          clr_ovf
);

    import fft8_pkg::state_t;
    import fft8_pkg::IDLE;
    import fft8_pkg::STREAM;
    import fft8_pkg::LAST_IDX;

    logic [DW-1:0] in_re [NBINS];
    logic [DW-1:0] in_im [NBINS];

    assign in_re[0] = in1_real;
    assign in_re[1] = in2_real;
    assign in_re[2] = in3_real;
    assign in_re[3] = in4_real;
    assign in_re[4] = in5_real;
    assign in_re[5] = in6_real;
    assign in_re[6] = in7_real;
    assign in_re[7] = in8_real;
    assign in_im[0] = in1_imag;
    assign in_im[1] = in2_imag;
    assign in_im[2] = in3_imag;
    assign in_im[3] = in4_imag;
    assign in_im[4] = in5_imag;
    assign in_im[5] = in6_imag;
    assign in_im[6] = in7_imag;
    assign in_im[7] = in8_imag;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic          ovf_q;
    logic          ovf_d;
    logic [DW-1:0] re_q [NBINS];
    logic [DW-1:0] im_q [NBINS];

    logic streaming;
    logic xfer;
    logic last_xfer;
    logic load;
    logic drop;

    assign streaming = (state_q == STREAM);
    assign xfer      = streaming && bin_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);
    // A strobe landing on the final transfer chains straight into the next frame.
    assign load      = in_stb && (!streaming || last_xfer);
    assign drop      = in_stb && streaming && !last_xfer;
    assign ovf_d     = drop || (ovf_q && !clr_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NBINS; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            if (load) begin
                for (int i = 0; i < NBINS; i++) begin
                    re_q[i] <= in_re[i];
                    im_q[i] <= in_im[i];
                end
            end
            case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (in_stb) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (load) begin
                        idx_q <= '0;
                    end else if (last_xfer) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else if (xfer) begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign bin_real  = re_q[idx_q];
    assign bin_imag  = im_q[idx_q];
    assign bin_idx   = idx_q;
    assign bin_valid = streaming;
    assign busy      = streaming;
    assign bin_last  = streaming && (idx_q == LAST_IDX);
    assign overflow  = ovf_q;

    fft8_mag_est #(
        .DW(DW)
    ) u_mag (
        .re_i (bin_real),
        .im_i (bin_imag),
        .mag_o(bin_mag)
    );

endmodule

// File: tb/tb_fft8_out_reader.sv
// Randomised bench for fft8_out_reader: a frame-level scoreboard predicts the
// presented bin, flags and overflow each cycle, plus directed corner scenarios.
module tb_fft8_out_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_stb;
    logic        bin_ready;
    logic        clr_ovf;
    logic [15:0] f_re [8];
    logic [15:0] f_im [8];
    logic [15:0] bin_real;
    logic [15:0] bin_imag;
    logic [2:0]  bin_idx;
    logic [15:0] bin_mag;
    logic        bin_valid;
    logic        bin_last;
    logic        busy;
    logic        overflow;
    logic [15:0] t_re;
    logic [15:0] t_im;
    logic [15:0] t_mag;

    always #5 clk = ~clk;

    fft8_out_reader #(.DW(16), .NBINS(8)) dut (
        .clk(clk), .rst(rst),
        .in1_real(f_re[0]), .in2_real(f_re[1]), .in3_real(f_re[2]), .in4_real(f_re[3]),
        .in5_real(f_re[4]), .in6_real(f_re[5]), .in7_real(f_re[6]), .in8_real(f_re[7]),
        .in1_imag(f_im[0]), .in2_imag(f_im[1]), .in3_imag(f_im[2]), .in4_imag(f_im[3]),
        .in5_imag(f_im[4]), .in6_imag(f_im[5]), .in7_imag(f_im[6]), .in8_imag(f_im[7]),
        .in_stb(in_stb), .bin_real(bin_real), .bin_imag(bin_imag), .bin_idx(bin_idx),
        .bin_mag(bin_mag), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .bin_last(bin_last), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    fft8_mag_est #(.DW(16)) u_mag_tb (.re_i(t_re), .im_i(t_im), .mag_o(t_mag));

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: the frame currently being delivered and the next bin due.
    bit          m_active;
    int          m_pos;
    bit          m_ovf;
    logic [15:0] m_re [8];
    logic [15:0] m_im [8];
    int          n_xfer = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int absq(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [15:0] mag_ref(input logic [15:0] re, input logic [15:0] im);
        int a, b, mx, mn;
        a  = absq(re);
        b  = absq(im);
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return 16'(mx + mn / 2);
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_ovf    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_re[i] = 16'h0;
            m_im[i] = 16'h0;
        end
    endtask

    // One clock: check the DUT against the scoreboard, then advance the scoreboard.
    task automatic step();
        bit xfer, lastx, drop;
        @(negedge clk);
        chk("valid", bin_valid, m_active);
        chk("busy", busy, m_active);
        chk("last", bin_last, m_active && (m_pos == 7));
        chk("overflow", overflow, m_ovf);
        if (m_active) begin
            chk("idx", bin_idx, m_pos);
            chk("real", bin_real, m_re[m_pos]);
            chk("imag", bin_imag, m_im[m_pos]);
            chk("mag", bin_mag, mag_ref(m_re[m_pos], m_im[m_pos]));
        end
        if (rst) begin
            model_reset();
        end else begin
            xfer  = m_active && bin_ready;
            lastx = xfer && (m_pos == 7);
            drop  = 1'b0;
            if (xfer) n_xfer++;
            if (in_stb && (!m_active || lastx)) begin
                for (int i = 0; i < 8; i++) begin
                    m_re[i] = f_re[i];
                    m_im[i] = f_im[i];
                end
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                drop = in_stb && m_active;
                if (lastx) begin
                    m_active = 1'b0;
                    m_pos    = 0;
                end else if (xfer) begin
                    m_pos++;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) begin
            f_re[i] = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
            f_im[i] = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
        end
    endtask

    // 8-point DFT of the Q8.8 ramp 0..7, as the FFT8 core would emit it.
    task automatic ramp_frame();
        real sr, si, ang;
        for (int k = 0; k < 8; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 8; n++) begin
                ang = 2.0 * 3.14159265358979 * k * n / 8.0;
                sr  = sr + n * 256.0 * $cos(ang);
                si  = si - n * 256.0 * $sin(ang);
            end
            f_re[k] = 16'(rnd(sr));
            f_im[k] = 16'(rnd(si));
        end
    endtask

    task automatic wait_pos(input int p);
        int c = 0;
        while (m_pos != p && c < 20) begin
            step();
            c++;
        end
        chk("wait_idx", bin_idx, p);
    endtask

    task automatic strobe();
        in_stb = 1'b1;
        step();
        in_stb = 1'b0;
    endtask

    initial begin
        int n0, c;
        rst = 1'b1; in_stb = 1'b0; bin_ready = 1'b0; clr_ovf = 1'b0;
        t_re = 16'h0; t_im = 16'h0;
        for (int i = 0; i < 8; i++) begin
            f_re[i] = 16'h0;
            f_im[i] = 16'h0;
        end
        model_reset();
        #2;
        chk("rst_valid", bin_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last", bin_last, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_idx", bin_idx, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        t_re = 16'h8000; t_im = 16'h8000; #1;
        chk("mag_min_min", t_mag, 16'hC000);
        t_re = 16'h0300; t_im = 16'hFC00; #1;
        chk("mag_3_m4", t_mag, 16'h0580);
        for (int i = 0; i < 20; i++) begin
            t_re = 16'($urandom); t_im = 16'($urandom); #1;
            chk("mag_rand", t_mag, mag_ref(t_re, t_im));
        end

        // Ramp frame, always ready.
        ramp_frame();
        bin_ready = 1'b1;
        strobe();
        chk("ramp_b0_valid", bin_valid, 1'b1);
        chk("ramp_b0_re", bin_real, 16'h1C00);
        chk("ramp_b0_im", bin_imag, 16'h0000);
        chk("ramp_b0_mag", bin_mag, 16'h1C00);
        for (int i = 0; i < 4; i++) step();
        chk("ramp_b4_idx", bin_idx, 3'd4);
        chk("ramp_b4_re", bin_real, 16'hFC00);
        chk("ramp_b4_mag", bin_mag, 16'h0400);
        for (int i = 0; i < 5; i++) step();

        // Ramp frame with ready pattern 1,0,0,...
        ramp_frame();
        bin_ready = 1'b0;
        strobe();
        n0 = n_xfer;
        c = 0;
        while ((n_xfer - n0) < 8 && c < 60) begin
            bin_ready = (c % 3 == 0);
            step();
            c++;
        end
        chk("stall_count", n_xfer - n0, 8);
        bin_ready = 1'b1;
        for (int i = 0; i < 2; i++) step();

        // Back-to-back frames on the last transfer.
        rand_frame();
        strobe();
        wait_pos(7);
        rand_frame();
        strobe();
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_idx", bin_idx, 3'd0);
        chk("b2b_ovf", overflow, 1'b0);
        for (int i = 0; i < 9; i++) step();

        // Dropped frame at idx 3, then clear-vs-set priority.
        rand_frame();
        strobe();
        wait_pos(3);
        rand_frame();
        strobe();
        chk("drop_ovf", overflow, 1'b1);
        wait_pos(5);
        in_stb = 1'b1; clr_ovf = 1'b1;
        step();
        in_stb = 1'b0;
        chk("clr_and_drop", overflow, 1'b1);
        step();
        clr_ovf = 1'b0;
        chk("clr_alone", overflow, 1'b0);
        for (int i = 0; i < 3; i++) step();

        // Reset mid-frame at idx 5.
        rand_frame();
        strobe();
        wait_pos(5);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", bin_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_idx", bin_idx, 3'd0);
        chk("mrst_last", bin_last, 1'b0);
        model_reset();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rand_frame();
        strobe();
        chk("restart_idx", bin_idx, 3'd0);
        chk("restart_valid", bin_valid, 1'b1);
        for (int i = 0; i < 9; i++) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_stb = ($urandom_range(0, 5) == 0);
            if (in_stb) rand_frame();
            bin_ready = ($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            step();
        end
        in_stb = 1'b0; clr_ovf = 1'b0; bin_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
